iob_eth_rx_deframer: RTL and testbench

IOB_ETH_RX_DEFRAMER -- requirements
Module: iob_eth_rx_deframer

---
 rtl/iob_eth_rx_deframer.sv | 98 +++++++++
 tb/tb_iob_eth_rx_deframer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_eth_rx_deframer.sv
// iob_eth_rx_deframer: MII nibble deframer writing frame bytes into a receive buffer.
// Define ETH_RX_CRC_EN to add the FCS check that drives crc_err.
`timescale 1ns / 1ps
module iob_eth_rx_deframer #(
    parameter int BUF_ADDR_W = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_dv,
    input  logic [3:0]            rx_data,
    output logic                  wr_en,
    output logic [BUF_ADDR_W-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  rx_ready,
    input  logic                  rx_ack,
    output logic [BUF_ADDR_W:0]   rx_nbytes,
    output logic                  overflow,
    output logic                  crc_err
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, DROP, DONE} state_t;
    state_t state, state_nx;
    logic dv_q, half, lost, crc_bad, sfd, byte_in;
    logic [3:0] lo;
    logic [BUF_ADDR_W:0] cnt;
    assign sfd       = state == PREAMBLE && rx_dv && rx_data == 4'hd;
    assign byte_in   = state == DATA && rx_dv && half;
    assign rx_nbytes = cnt;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (rx_dv) state_nx = (rx_data == 4'h5 && !dv_q) ? PREAMBLE : DROP;
            PREAMBLE: state_nx = !rx_dv ? IDLE : rx_data == 4'h5 ? PREAMBLE : rx_data == 4'hd ? DATA : DROP;
            DATA:     if (!rx_dv) state_nx = cnt == '0 ? IDLE : DONE;
            DROP:     if (!rx_dv) state_nx = IDLE;
            DONE:     if (rx_ack) state_nx = rx_dv ? DROP : IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        rx_ready = state == DONE;
        overflow = rx_ready && lost;
        crc_err  = rx_ready && crc_bad;
    end

    // dv_q resets high so a frame still in flight at reset release is dropped, not taken as preamble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_q    <= 1'b1;
            half    <= 1'b0;
            lost    <= 1'b0;
            lo      <= '0;
            cnt     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            dv_q  <= rx_dv;
            wr_en <= byte_in && !cnt[BUF_ADDR_W];
            if (sfd) begin
                cnt  <= '0;
                half <= 1'b0;
                lost <= 1'b0;
            end else if (state == DATA && rx_dv) begin
                half <= !half;
                if (!half) lo <= rx_data;
                else if (cnt[BUF_ADDR_W]) lost <= 1'b1;
                else begin
                    wr_addr <= cnt[BUF_ADDR_W-1:0];
                    wr_data <= {rx_data, lo};
                    cnt     <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef ETH_RX_CRC_EN
    logic [31:0] crc;
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) r = (r >> 1) ^ (r[0] ? 32'hedb88320 : 32'h0);
        return r;
    endfunction
    // running over the FCS too leaves the fixed residue on a good frame
    always_ff @(posedge clk or posedge rst)
        if (rst || sfd) crc <= '1;
        else if (byte_in && !cnt[BUF_ADDR_W]) crc <= crc_next(crc, {rx_data, lo});
    assign crc_bad = crc != 32'hdebb20e3;
`else
    assign crc_bad = 1'b0;
`endif
endmodule

// File: tb/tb_iob_eth_rx_deframer.sv
// tb_iob_eth_rx_deframer: random and directed frames into a 2048-byte and a 16-byte deframer,
// checked against a frame-level model of expected writes and held status.
`timescale 1ns / 1ps
module tb_iob_eth_rx_deframer;
    typedef logic [7:0] bq_t[$];
    logic clk = 0, rst = 1, rx_dv = 0, rx_ack = 0;
    logic [3:0] rx_data = 0;
    logic wr_en_a, rx_ready_a, overflow_a, crc_err_a, wr_en_b, rx_ready_b, overflow_b, crc_err_b;
    logic [10:0] wr_addr_a;
    logic [11:0] rx_nbytes_a;
    logic [3:0] wr_addr_b;
    logic [4:0] rx_nbytes_b;
    logic [7:0] wr_data_a, wr_data_b;
    int tests = 0, fails = 0;
    int qa[$], qb[$];
    bit held = 0, exp_ovf_a, exp_ovf_b, exp_crc_a, exp_crc_b;
    int exp_na, exp_nb;
    bq_t fr;

    always #5 clk = ~clk;

    iob_eth_rx_deframer #(.BUF_ADDR_W(11)) dut_a (
        .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_data(rx_data), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .rx_ready(rx_ready_a), .rx_ack(rx_ack), .rx_nbytes(rx_nbytes_a),
        .overflow(overflow_a), .crc_err(crc_err_a));
    iob_eth_rx_deframer #(.BUF_ADDR_W(4)) dut_b (
        .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_data(rx_data), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .rx_ready(rx_ready_b), .rx_ack(rx_ack), .rx_nbytes(rx_nbytes_b),
        .overflow(overflow_b), .crc_err(crc_err_b));

    task automatic chk(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] crc32(input bq_t b, input int n);
        logic [31:0] c = '1;
        for (int i = 0; i < n; i++) begin
            c ^= {24'd0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hedb88320 : c >> 1;
        end
        return ~c;
    endfunction

    // a held frame fails its check unless its last four written bytes are the FCS of the rest
    function automatic bit model_crc_bad(input bq_t b, input int n);
`ifdef ETH_RX_CRC_EN
        if (n < 4) return 1'b1;
        return crc32(b, n - 4) != {b[n-1], b[n-2], b[n-3], b[n-4]};
`else
        return 1'b0;
`endif
    endfunction

    task automatic expect_frame(input bq_t b);
        int n = b.size();
        if (held || n == 0) return;
        exp_na = n < 2048 ? n : 2048;
        exp_nb = n < 16 ? n : 16;
        for (int i = 0; i < exp_na; i++) qa.push_back(i * 256 + int'(b[i]));
        for (int i = 0; i < exp_nb; i++) qb.push_back(i * 256 + int'(b[i]));
        exp_ovf_a = n > 2048;
        exp_ovf_b = n > 16;
        exp_crc_a = model_crc_bad(b, exp_na);
        exp_crc_b = model_crc_bad(b, exp_nb);
        held = 1;
    endtask

    task automatic nib(input logic dv, input logic [3:0] d);
        @(negedge clk);
        rx_dv = dv;
        rx_data = d;
    endtask

    task automatic send_byte(input logic [7:0] b);
        nib(1, b[3:0]);
        nib(1, b[7:4]);
    endtask

    task automatic send_frame(input bq_t b, input bit odd, input bit noise);
        for (int i = 0; i < 15; i++) begin
            nib(1, 4'h5);
            rx_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        nib(1, 4'hd);
        rx_ack = 0;
        foreach (b[i]) send_byte(b[i]);
        if (odd) nib(1, 4'($urandom));
        nib(0, 0);
        nib(0, 0);
    endtask

    task automatic run_frame(input bq_t b, input bit odd);
        bit noise = !held;
        expect_frame(b);
        send_frame(b, odd, noise);
    endtask

    task automatic check_status();
        chk("ready_a", rx_ready_a, held);
        chk("ready_b", rx_ready_b, held);
        chk("ovf_a", overflow_a, held && exp_ovf_a);
        chk("ovf_b", overflow_b, held && exp_ovf_b);
        chk("crc_a", crc_err_a, held && exp_crc_a);
        chk("crc_b", crc_err_b, held && exp_crc_b);
        if (held) begin
            chk("nbytes_a", rx_nbytes_a, exp_na);
            chk("nbytes_b", rx_nbytes_b, exp_nb);
        end
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);
    endtask

    task automatic ack();
        @(negedge clk);
        rx_ack = 1;
        @(negedge clk);
        rx_ack = 0;
        held = 0;
        chk("ack_ready_a", rx_ready_a, 0);
        chk("ack_ready_b", rx_ready_b, 0);
    endtask

    task automatic rand_bytes(input int n);
        fr = {};
        for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
    endtask

    task automatic add_fcs();
        logic [31:0] c = crc32(fr, fr.size());
        for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
    endtask

    initial begin
        int ea, eb;
        forever begin
            @(posedge clk);
            #1;
            if (wr_en_a) begin
                ea = qa.size() != 0 ? qa.pop_front() : -1;
                chk("write_a", int'({wr_addr_a, wr_data_a}), ea);
            end
            if (wr_en_b) begin
                eb = qb.size() != 0 ? qb.pop_front() : -1;
                chk("write_b", int'({wr_addr_b, wr_data_b}), eb);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bq_t t;
        #3;
        chk("rst_wr_en", wr_en_a, 0);
        chk("rst_ready", rx_ready_a, 0);
        chk("rst_nbytes", rx_nbytes_a, 0);
        @(negedge clk);
        rst = 0;
        t = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("model_crc", crc32(t, 9), 32'hcbf43926);
        fr = {};
        for (int i = 1; i <= 64; i++) fr.push_back(8'(i));
        run_frame(fr, 0);
        check_status();
        chk("lit_n_a", rx_nbytes_a, 64);
        chk("lit_n_b", rx_nbytes_b, 16);
        chk("lit_ovf_a", overflow_a, 0);
        chk("lit_ovf_b", overflow_b, 1);
        ack();
        rand_bytes(60);
        add_fcs();
        run_frame(fr, 0);
        check_status();
        chk("lit_fcs_n", rx_nbytes_a, 64);
        chk("lit_fcs_crc", crc_err_a, 0);
        ack();
        fr[7] ^= 8'h10;
        run_frame(fr, 1);
        check_status();
        ack();
        rand_bytes(20);
        run_frame(fr, 0);
        check_status();
        chk("lit20_n_b", rx_nbytes_b, 16);
        chk("lit20_ovf_b", overflow_b, 1);
        ack();
        rand_bytes(8);
        for (int i = 0; i < 2; i++) nib(1, 4'h5);
        nib(1, 4'h3);
        foreach (fr[i]) send_byte(fr[i]);
        nib(0, 0);
        nib(0, 0);
        check_status();
        chk("lit_badpre", rx_ready_a, 0);
        fr = {};
        run_frame(fr, 1);
        check_status();
        rand_bytes(12);
        run_frame(fr, 0);
        check_status();
        rand_bytes(9);
        run_frame(fr, 1);
        check_status();
        chk("lit_held_n", rx_nbytes_a, 12);
        ack();
        rand_bytes(5);
        run_frame(fr, 0);
        check_status();
        ack();
        for (int r = 0; r < 10; r++) begin
            rand_bytes($urandom_range(0, 36));
            if ($urandom_range(0, 1) != 0) add_fcs();
            else for (int i = 0; i < 4; i++) fr.push_back(8'($urandom));
            run_frame(fr, 1'($urandom_range(0, 1)));
            check_status();
            ack();
        end
        rand_bytes(10);
        for (int i = 0; i < 10; i++) begin
            qa.push_back(i * 256 + int'(fr[i]));
            qb.push_back(i * 256 + int'(fr[i]));
        end
        for (int i = 0; i < 15; i++) nib(1, 4'h5);
        nib(1, 4'hd);
        foreach (fr[i]) send_byte(fr[i]);
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        chk("mid_rst_wr_en", wr_en_a, 0);
        chk("mid_rst_addr", wr_addr_a, 0);
        chk("mid_rst_data", wr_data_a, 0);
        chk("mid_rst_n", rx_nbytes_a, 0);
        chk("mid_rst_n_b", rx_nbytes_b, 0);
        nib(1, 4'h5);
        nib(1, 4'h5);
        rst = 0;
        send_byte(8'h55);
        send_byte(8'h55);
        send_byte(8'hd5);
        send_byte(8'h5d);
        nib(0, 0);
        nib(0, 0);
        check_status();
        rand_bytes(6);
        run_frame(fr, 0);
        check_status();
        chk("post_rst_n", rx_nbytes_a, 6);
        ack();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
